fpu_op_scheduler: RTL and testbench

//  Queues FPU operation commands and sequences them one at a time onto a set of
//  FPU op units (ConvolutionBackward-style blocks with a go/done handshake).
//  One unit runs at a time, selected by opcode; each command produces one tagged

---
 rtl/fpu_op_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_fpu_op_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_op_scheduler.sv
// fpu_op_scheduler: queues {op,tag} commands, runs one FPU unit at a time over go/done.
// Optional watchdog: define FPU_SCHED_TIMEOUT_EN to end a stuck RUN with err=2.
module fpu_op_scheduler #(
    parameter int NUM_UNITS      = 4,
    parameter int OP_W           = 3,
    parameter int TAG_W          = 8,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OP_W-1:0]      cmd_op,
    input  logic [TAG_W-1:0]     cmd_tag,
    output logic [NUM_UNITS-1:0] unit_go,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [1:0]           rsp_err,
    output logic                 busy,
    output logic [15:0]          op_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1
        || OP_W < IDX_W) begin : g_bad_cfg
        $error("fpu_op_scheduler: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [OP_W-1:0]      fifo_op  [DEPTH];
    logic [TAG_W-1:0]     fifo_tag [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]       count_q;
    logic [IDX_W-1:0]     cur_idx_q, cur_idx_d;
    logic [TAG_W-1:0]     cur_tag_q, cur_tag_d;
    logic [NUM_UNITS-1:0] go_q, go_d;
    logic [1:0]           err_q, err_d;
    logic [15:0]          op_count_q, op_count_d;
    logic                 push, pop, head_bad, done_cur;
    logic [OP_W-1:0]      head_op;
    logic [TAG_W-1:0]     head_tag;
`ifdef FPU_SCHED_TIMEOUT_EN
    logic [31:0]          tmo_q, tmo_d;
    logic                 tmo_hit;
    assign tmo_hit = (tmo_q == 32'(TIMEOUT_CYCLES - 1));
`endif

    assign cmd_ready = (count_q != FULL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign head_op   = fifo_op[rd_ptr_q];
    assign head_tag  = fifo_tag[rd_ptr_q];
    assign head_bad  = (int'(head_op) >= NUM_UNITS);
    assign done_cur  = unit_done[cur_idx_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr_q]  <= cmd_op;
            fifo_tag[wr_ptr_q] <= cmd_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_idx_q  <= '0;
            cur_tag_q  <= '0;
            go_q       <= '0;
            err_q      <= '0;
            op_count_q <= '0;
`ifdef FPU_SCHED_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cur_idx_q  <= cur_idx_d;
            cur_tag_q  <= cur_tag_d;
            go_q       <= go_d;
            err_q      <= err_d;
            op_count_q <= op_count_d;
`ifdef FPU_SCHED_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (pop) state_d = head_bad ? S_RESP : S_ISSUE;
            S_ISSUE: if (!done_cur) state_d = S_RUN;
            S_RUN: begin
                if (done_cur) state_d = S_RESP;
`ifdef FPU_SCHED_TIMEOUT_EN
                else if (tmo_hit) state_d = S_RESP;
`endif
            end
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
        endcase
    end

    // Datapath next-state; go is registered so it drops the cycle after done.
    always_comb begin
        cur_idx_d  = cur_idx_q;
        cur_tag_d  = cur_tag_q;
        go_d       = go_q;
        err_d      = err_q;
        op_count_d = op_count_q;
`ifdef FPU_SCHED_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cur_idx_d = head_op[IDX_W-1:0];
                    cur_tag_d = head_tag;
                    err_d     = head_bad ? 2'd1 : 2'd0;
                end
            end
            S_ISSUE: begin
                if (!done_cur) begin
                    go_d            = '0;
                    go_d[cur_idx_q] = 1'b1;
                end
`ifdef FPU_SCHED_TIMEOUT_EN
                tmo_d = '0;
`endif
            end
            S_RUN: begin
                if (done_cur) begin
                    go_d  = '0;
                    err_d = 2'd0;
                end
`ifdef FPU_SCHED_TIMEOUT_EN
                else if (tmo_hit) begin
                    go_d  = '0;
                    err_d = 2'd2;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) op_count_d = op_count_q + 16'd1;
            end
        endcase
    end

    always_comb begin
        unit_go   = go_q;
        rsp_valid = (state_q == S_RESP);
        rsp_tag   = cur_tag_q;
        rsp_err   = err_q;
        op_count  = op_count_q;
        busy      = (count_q != '0) || (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// tb_fpu_op_scheduler: directed + random commands against a queue-based reference model.
// Unit models raise done a programmable number of cycles after go (-1 = never).
module tb_fpu_op_scheduler;
    localparam int NU  = 4;
    localparam int TMO = 16;
`ifdef FPU_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct {
        int         op;
        logic [7:0] tag;
        logic [1:0] err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [7:0]    cmd_tag;
    logic [NU-1:0] unit_go;
    logic [NU-1:0] unit_done;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [7:0]    rsp_tag;
    logic [1:0]    rsp_err;
    logic          busy;
    logic [15:0]   op_count;

    int            n_checks = 0;
    int            n_pass = 0;
    exp_t          exp_q[$];
    int            exp_cnt = 0;
    int            delay[NU];
    int            cnt[NU];
    logic [NU-1:0] done_r = '0;
    logic [NU-1:0] prev_go = '0;
    logic [NU-1:0] prev_done = '0;

    fpu_op_scheduler #(
        .NUM_UNITS(NU), .OP_W(3), .TAG_W(8), .DEPTH(4), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .unit_go(unit_go), .unit_done(unit_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;
    assign unit_done = done_r;

    always @(posedge clk) begin
        for (int i = 0; i < NU; i++) begin
            if (!unit_go[i]) begin
                done_r[i] <= 1'b0;
                cnt[i]    <= 0;
            end else begin
                cnt[i] <= cnt[i] + 1;
                if (delay[i] >= 0 && cnt[i] + 1 >= delay[i]) done_r[i] <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Go may only target the unit of the oldest outstanding command.
    always @(negedge clk) begin
        if (!rst) begin
            if (unit_go != '0)
                chk("go_onehot", 32'(unit_go),
                    (exp_q.size() > 0) ? (32'd1 << exp_q[0].op) : 32'd0);
            for (int i = 0; i < NU; i++)
                if (prev_go[i] && prev_done[i]) chk("go_drop", 32'(unit_go[i]), 0);
        end
        prev_go   <= unit_go;
        prev_done <= unit_done;
    end

    function automatic logic [1:0] exp_err(input int op, input int d);
        if (op >= NU) return 2'd1;
        if (TMO_EN && (d < 0 || d >= TMO)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic push(input int op, input logic [7:0] tag, input logic [1:0] err);
        exp_t e;
        bit   ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op[2:0];
        cmd_tag   = tag;
        for (int k = 0; k < 300 && !ok; k++) begin
            if (cmd_ready) begin
                @(posedge clk);
                e.op  = op;
                e.tag = tag;
                e.err = err;
                exp_q.push_back(e);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        if (!ok) cmd_valid = 1'b0;
        chk("push_accept", 32'(ok), 1);
    endtask

    task automatic drain(input int n);
        rsp_ready = 1'b1;
        for (int j = 0; j < n; j++) begin
            bit got;
            got = 1'b0;
            for (int k = 0; k < 300 && !got; k++) begin
                if (rsp_valid) begin
                    got = 1'b1;
                    chk("rsp_tag", 32'(rsp_tag), 32'(exp_q[0].tag));
                    chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
                    chk("op_count_pre", 32'(op_count), exp_cnt);
                    @(posedge clk);
                    void'(exp_q.pop_front());
                    exp_cnt++;
                end
                @(negedge clk);
            end
            chk("rsp_seen", 32'(got), 1);
        end
        rsp_ready = 1'b0;
        chk("op_count", 32'(op_count), exp_cnt);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   seen;
        int   hi;
        int   op;
        int   n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_tag   = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NU; i++) delay[i] = 1;
        repeat (3) @(negedge clk);
        chk("rst_go", 32'(unit_go), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_tag", 32'(rsp_tag), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_op_count", 32'(op_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        // single op on unit 1
        delay[1] = 5;
        push(1, 8'h11, exp_err(1, 5));
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (unit_go[1]) seen = 1'b1;
            else @(negedge clk);
        end
        chk("t1_go_seen", 32'(seen), 1);
        drain(1);

        // fill FIFO with stalled units, then release
        for (int i = 0; i < NU; i++) delay[i] = -1;
        for (int i = 0; i < 5; i++) begin
            op = $urandom_range(0, NU - 1);
            push(op, 8'(8'hA0 + i), exp_err(op, 3));
        end
        cmd_valid = 1'b0;
        chk("t2_full_ready", 32'(cmd_ready), 0);
        chk("t2_busy", 32'(busy), 1);
        for (int i = 0; i < NU; i++) delay[i] = 3;
        drain(5);

        // bad opcode
        push(5, 8'h22, exp_err(5, 0));
        cmd_valid = 1'b0;
        drain(1);
        chk("t3_go_idle", 32'(unit_go), 0);

        // response back-pressure
        delay[0] = 2;
        delay[1] = 2;
        push(0, 8'h44, exp_err(0, 2));
        push(1, 8'h45, exp_err(1, 2));
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            if (rsp_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("t4_rsp_seen", 32'(seen), 1);
        repeat (10) begin
            @(negedge clk);
            chk("t4_valid_hold", 32'(rsp_valid), 1);
            chk("t4_tag_hold", 32'(rsp_tag), 32'(exp_q[0].tag));
            chk("t4_err_hold", 32'(rsp_err), 32'(exp_q[0].err));
            chk("t4_no_issue", 32'(unit_go), 0);
        end
        drain(2);

        // asynchronous reset during RUN
        delay[2] = -1;
        push(2, 8'h55, 2'd0);
        push(0, 8'h56, 2'd0);
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (unit_go[2]) seen = 1'b1;
            else @(negedge clk);
        end
        chk("t5_go2_seen", 32'(seen), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_go", 32'(unit_go), 0);
        chk("t5_rsp_valid", 32'(rsp_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_cmd_ready", 32'(cmd_ready), 1);
        chk("t5_op_count", 32'(op_count), 0);
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst      = 1'b0;
        delay[2] = 3;
        @(negedge clk);

        // random batches
        repeat (8) begin
            for (int i = 0; i < NU; i++) delay[i] = $urandom_range(1, 8);
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                op = $urandom_range(0, 5);
                push(op, 8'($urandom), exp_err(op, (op < NU) ? delay[op] : 0));
            end
            cmd_valid = 1'b0;
            drain(n);
        end

`ifdef FPU_SCHED_TIMEOUT_EN
        // watchdog: never done, done on the last RUN cycle, one cycle too late
        delay[3] = -1;
        push(3, 8'h61, exp_err(3, -1));
        cmd_valid = 1'b0;
        hi = 0;
        for (int k = 0; k < 100 && !rsp_valid; k++) begin
            if (unit_go[3]) hi++;
            @(negedge clk);
        end
        chk("t6_go_cycles", hi, TMO);
        drain(1);
        delay[3] = TMO - 1;
        push(3, 8'h62, exp_err(3, TMO - 1));
        cmd_valid = 1'b0;
        drain(1);
        delay[3] = TMO;
        push(3, 8'h63, exp_err(3, TMO));
        cmd_valid = 1'b0;
        drain(1);
`else
        hi = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
